// File: rtl/accum_sequencer_if.sv
// Command, slice-stream and accumulator-drive signals of the accumulator sequencer.
// The master side issues commands and slice valids; the slave side is the sequencer.
interface accum_sequencer_if #(
   parameter int ACCUM_ADDRW = 9,
   parameter int PASSW       = 8
);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [ACCUM_ADDRW-1:0] cmd_base;
   logic [ACCUM_ADDRW:0]   cmd_rows;
   logic [PASSW-1:0]       cmd_passes;
   logic                   slice_valid;
   logic                   slice_ready;
   logic                   accum_valid;
   logic [ACCUM_ADDRW-1:0] accum_addr;
   logic [1:0]             accum_op;
   logic                   busy;
   logic                   done;

   modport master (
      output cmd_valid, cmd_base, cmd_rows, cmd_passes, slice_valid,
      input  cmd_ready, slice_ready, accum_valid, accum_addr, accum_op, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_base, cmd_rows, cmd_passes, slice_valid,
      output cmd_ready, slice_ready, accum_valid, accum_addr, accum_op, busy, done
   );
endinterface

// File: rtl/accum_sequencer.sv
// Walks base..base+rows-1 once per pass, tagging each slice result with an
// accumulator address/op and stalling when an address would be reused too soon.
module accum_sequencer #(
   parameter int ACCUM_DEPTH = 512,
   parameter int ACCUM_ADDRW = $clog2(ACCUM_DEPTH),
   parameter int PASSW       = 8,
   parameter int HAZARD_GAP  = 4
) (
   input logic              clk,
   input logic              rst,
   accum_sequencer_if.slave bus
);
   localparam int SB_DEPTH = HAZARD_GAP - 1;

   localparam logic [1:0] OP_SET     = 2'd0;
   localparam logic [1:0] OP_ADD     = 2'd1;
   localparam logic [1:0] OP_ADD_OUT = 2'd2;
   localparam logic [1:0] OP_SET_OUT = 2'd3;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 state;
   state_t                 state_next;
   logic [ACCUM_ADDRW-1:0] base;
   logic [ACCUM_ADDRW:0]   rows;
   logic [ACCUM_ADDRW:0]   row_cnt;
   logic [PASSW-1:0]       passes;
   logic [PASSW-1:0]       pass_cnt;
   logic                   done_q;
   logic [ACCUM_ADDRW-1:0] cand_addr;
   logic [SB_DEPTH-1:0]    sb_valid;
   logic [ACCUM_ADDRW-1:0] sb_addr [SB_DEPTH];
   logic                   hazard;
   logic                   issue;
   logic                   accept;
   logic                   zero_len;
   logic                   last_row;
   logic                   last_pass;
   logic                   cmd_ready;
   logic                   slice_ready;
   logic                   busy;
   logic [1:0]             op;

   // Address arithmetic wraps naturally at the address width.
   assign cand_addr = base + row_cnt[ACCUM_ADDRW-1:0];
   assign last_row  = (row_cnt == rows - 1'b1);
   assign last_pass = (pass_cnt == passes - 1'b1);
   assign zero_len  = (bus.cmd_rows == '0) || (bus.cmd_passes == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Reset gates every handshake so a mid-command reset stops issuing at once.
   always_comb begin
      state_next  = state;
      cmd_ready   = 1'b0;
      slice_ready = 1'b0;
      issue       = 1'b0;
      accept      = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = ~rst;
            accept    = ~rst & bus.cmd_valid;
            if (accept && !zero_len) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy        = ~rst;
            slice_ready = ~rst & ~hazard;
            issue       = slice_ready & bus.slice_valid;
            if (issue && last_row && last_pass) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      if (passes == PASSW'(1)) begin
         op = OP_SET_OUT;
      end else if (pass_cnt == '0) begin
         op = OP_SET;
      end else if (last_pass) begin
         op = OP_ADD_OUT;
      end else begin
         op = OP_ADD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base     <= '0;
         rows     <= '0;
         passes   <= '0;
         row_cnt  <= '0;
         pass_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (accept && zero_len) || (issue && last_row && last_pass);
         if (accept) begin
            base     <= bus.cmd_base;
            rows     <= bus.cmd_rows;
            passes   <= bus.cmd_passes;
            row_cnt  <= '0;
            pass_cnt <= '0;
         end else if (issue) begin
            if (last_row) begin
               row_cnt  <= '0;
               pass_cnt <= pass_cnt + 1'b1;
            end else begin
               row_cnt <= row_cnt + 1'b1;
            end
         end
      end
   end

   // Kept across commands so back-to-back commands still respect the gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_valid <= '0;
      end else begin
         sb_valid[0] <= issue;
         for (int i = 1; i < SB_DEPTH; i++) begin
            sb_valid[i] <= sb_valid[i-1];
         end
      end
      sb_addr[0] <= cand_addr;
      for (int i = 1; i < SB_DEPTH; i++) begin
         sb_addr[i] <= sb_addr[i-1];
      end
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_valid[i] && (sb_addr[i] == cand_addr)) begin
            hazard = 1'b1;
         end
      end
   end

   assign bus.cmd_ready   = cmd_ready;
   assign bus.slice_ready = slice_ready;
   assign bus.accum_valid = issue;
   assign bus.accum_addr  = cand_addr;
   assign bus.accum_op    = op;
   assign bus.busy        = busy;
   assign bus.done        = done_q;
endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Command-driven sequencer that drives the address/op/valid inputs of the tile accumulator (SET=0, ADD=1, ADD_OUT=2, SET_OUT=3). It sits between the slice output stream and the accumulator.

- It accepts one reduction command at a time: base address, row count and pass count.
- It tags each incoming slice result with its accumulator address and op, and gates the slice stream with a ready signal.
- It enforces the accumulator's read-modify-write hazard distance: it stalls whenever the next address was issued fewer than HAZARD_GAP cycles earlier.

## Interface
- ACCUM_DEPTH, 512, accumulator entries
- ACCUM_ADDRW, $clog2(ACCUM_DEPTH), address width
- PASSW, 8, width of pass count
- HAZARD_GAP, 4, minimum cycle distance between two issues to the same address (accumulator read-to-write-commit latency + 1)

- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  command accepted when valid & ready
- i_cmd_base  in  ACCUM_ADDRW  first accumulator address
- i_cmd_rows  in  ACCUM_ADDRW+1  rows per pass, legal 0..ACCUM_DEPTH
- i_cmd_passes  in  PASSW  number of passes, legal 0..2^PASSW-1
- i_slice_valid  in  1  slice result available
- o_slice_ready  out  1  slice result consumed when valid & ready
- o_accum_valid  out  1  to accumulator i_valid
- o_accum_addr  out  ACCUM_ADDRW  to accumulator i_accum_addr
- o_accum_op  out  2  to accumulator i_accum_op
- o_busy  out  1  command in progress
- o_done  out  1  one-cycle pulse, command complete

## Operation
- States are IDLE and RUN.
  - IDLE: o_cmd_ready=1. On accept, the block latches base/rows/passes, clears row_cnt and pass_cnt, and moves to RUN.
  - If rows==0 or passes==0, the block stays in IDLE, pulses o_done next cycle and issues nothing.
- RUN: o_cmd_ready=0, o_busy=1.
- Issue: issue = RUN & i_slice_valid & ~hazard.
  - o_slice_ready = RUN & ~hazard.
  - o_accum_valid = issue.
- o_accum_addr = (base + row_cnt) mod 2^ACCUM_ADDRW (wraps past ACCUM_DEPTH-1 to 0 when ACCUM_DEPTH is a power of two).
- Op selection:
  - passes==1 → SET_OUT.
  - Otherwise: pass_cnt==0 → SET; pass_cnt==passes-1 → ADD_OUT; else ADD.
- Counters, on each issue:
  - row_cnt increments.
  - At row_cnt==rows-1, row_cnt clears and pass_cnt increments.
  - On the last row of the last pass, the block returns to IDLE and registers o_done.
- Hazard scoreboard:
  - A shift register of HAZARD_GAP-1 entries {valid, addr} shifts every cycle.
  - Entry 0 gets {issue, o_accum_addr}; a non-issue cycle inserts valid=0.
  - hazard = any valid entry's addr == o_accum_addr (the candidate address).
  - The scoreboard is not cleared between commands, which protects back-to-back commands that touch the same addresses.
- Upstream stalls only delay issue; the address order never changes.
- Outputs are combinational from registered state and the scoreboard; there is no combinational path from i_slice_valid to o_slice_ready.

## Timing
- Reset values: o_cmd_ready=0 while rst is high, and 1 from the first cycle after reset. o_slice_ready=0, o_accum_valid=0, o_accum_addr=0, o_accum_op=SET, o_busy=0, o_done=0. Scoreboard all invalid.
- Command accepted at cycle t → RUN at t+1; first issue possible at t+1.
- Throughput is one issue per cycle when rows ≥ HAZARD_GAP and i_slice_valid stays high. With rows < HAZARD_GAP, each pass occupies HAZARD_GAP cycles (HAZARD_GAP-rows bubble cycles).
- Same address issued at t and t' requires t'-t ≥ HAZARD_GAP, always.
- Last issue at cycle k: at k+1, o_done=1, o_busy=0 and o_cmd_ready=1. A new command accepted at k+1 issues from k+2.
- rst asserted mid-command aborts the command immediately. No o_done is produced, and the accumulator sees no further valid issues.
- i_cmd_* is ignored while in RUN.

## Test plan
- base=0, rows=8, passes=3, slice always valid, cmd at cycle 0:
  - cycles 1-24 issue addrs 0..7 three times, ops SET×8, ADD×8, ADD_OUT×8, with no stalls.
  - o_done at cycle 25.
- base=10, rows=2, passes=3:
  - addrs 10,11,-,-,10,11,-,-,10,11 over cycles 1-10.
  - ops SET,SET / ADD,ADD / ADD_OUT,ADD_OUT.
  - o_slice_ready low on bubble cycles; o_done at cycle 11.
- base=510, rows=4, passes=1: addrs 510,511,0,1, all SET_OUT; o_done one cycle after the fourth issue.
- rows=3, passes=2, base=0: i_slice_valid high only at cycles 1, 8, 9, then high from cycle 10.
  - Pass 0 issues at 1, 8, 9.
  - Pass 1 addr0 issues at 10, addr1 at 12 (stall at 11), addr2 at 13.
- Back-to-back: cmd A {base=5, rows=1, passes=1} then cmd B {base=5, rows=1, passes=1}.
  - B's issue is delayed until 4 cycles after A's issue.
- Zero-length and reset cases:
  - rows=0 command → o_done pulse at t+1 with no accum valid.
  - rst during pass 1 of a rows=8, passes=4 command → all outputs at reset values next cycle, no o_done; a new command afterwards starts cleanly with SET.
